// File: rtl/mem_wb_skid_reg.sv
// Elastic MEM/WB stage: 2-entry skid buffer, writeback select, r0 suppression, flush, saturating counters.
// Optional bypass outputs enabled by defining MEM_WB_BYPASS_EN.
module mem_wb_skid_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] readdata_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [REG_AW-1:0] write_reg_in,
    input  logic              regwrite_in,
    input  logic              memtoreg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_AW-1:0] wb_reg,
    output logic              wb_en,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  wb_count,
    output logic [CNT_W-1:0]  mem_read_count,
    output logic [CNT_W-1:0]  alu_result_count,
    output logic [CNT_W-1:0]  stall_count,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data
);

    typedef struct packed {
        logic [DATA_W-1:0] readdata;
        logic [DATA_W-1:0] alu;
        logic [REG_AW-1:0] write_reg;
        logic              regwrite;
        logic              memtoreg;
    } beat_t;

    beat_t             h_q, h_d, s_q, s_d, beat_in;
    logic              h_vld_q, h_vld_d, s_vld_q, s_vld_d;
    logic [CNT_W-1:0]  wb_cnt_q, wb_cnt_d;
    logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
    logic [CNT_W-1:0]  alu_cnt_q, alu_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              accept, fire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        return (en && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
    endfunction

    assign beat_in = '{readdata: readdata_in, alu: alu_in, write_reg: write_reg_in,
                       regwrite: regwrite_in, memtoreg: memtoreg_in};

    // in_ready comes straight from the skid valid flop: no path from out_ready
    assign in_ready = ~s_vld_q;
    assign accept   = in_valid & in_ready;
    assign fire     = h_vld_q & out_ready;
    assign wb_en    = fire & h_q.regwrite & (h_q.write_reg != '0);

    // Next-state for buffer slots and counters
    always_comb begin
        h_d         = h_q;
        s_d         = s_q;
        h_vld_d     = h_vld_q;
        s_vld_d     = s_vld_q;
        wb_cnt_d    = sat_inc(wb_cnt_q, wb_en);
        mem_cnt_d   = sat_inc(mem_cnt_q, wb_en & h_q.memtoreg);
        alu_cnt_d   = sat_inc(alu_cnt_q, wb_en & ~h_q.memtoreg);
        stall_cnt_d = sat_inc(stall_cnt_q, h_vld_q & ~out_ready);

        if (fire && s_vld_q) begin
            h_d     = s_q;
            s_vld_d = 1'b0;
        end else if (accept && (!h_vld_q || fire)) begin
            h_d     = beat_in;
            h_vld_d = 1'b1;
        end else if (accept && h_vld_q && !fire) begin
            s_d     = beat_in;
            s_vld_d = 1'b1;
        end else if (fire) begin
            h_vld_d = 1'b0;
        end

        if (flush) begin
            h_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q         <= '0;
            s_q         <= '0;
            h_vld_q     <= 1'b0;
            s_vld_q     <= 1'b0;
            wb_cnt_q    <= '0;
            mem_cnt_q   <= '0;
            alu_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            h_q         <= h_d;
            s_q         <= s_d;
            h_vld_q     <= h_vld_d;
            s_vld_q     <= s_vld_d;
            wb_cnt_q    <= wb_cnt_d;
            mem_cnt_q   <= mem_cnt_d;
            alu_cnt_q   <= alu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid        = h_vld_q;
    assign wb_data          = h_q.memtoreg ? h_q.readdata : h_q.alu;
    assign wb_reg           = h_q.write_reg;
    assign occupancy        = {1'b0, h_vld_q} + {1'b0, s_vld_q};
    assign wb_count         = wb_cnt_q;
    assign mem_read_count   = mem_cnt_q;
    assign alu_result_count = alu_cnt_q;
    assign stall_count      = stall_cnt_q;

`ifdef MEM_WB_BYPASS_EN
    beat_t young;
    logic  young_vld;

    // Youngest buffered entry is what a dependent instruction must see
    always_comb begin
        young     = s_vld_q ? s_q : h_q;
        young_vld = s_vld_q | h_vld_q;
    end

    assign fwd_valid = young_vld & young.regwrite & (young.write_reg != '0);
    assign fwd_reg   = young.write_reg;
    assign fwd_data  = young.memtoreg ? young.readdata : young.alu;
`else
    assign fwd_valid = 1'b0;
    assign fwd_reg   = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Self-checking bench for mem_wb_skid_reg: vector table plus FIFO scoreboard and counter model.
module tb_mem_wb_skid_reg;

    logic        clk;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] readdata_in, alu_in;
    logic [4:0]  write_reg_in;
    logic        regwrite_in, memtoreg_in;

    logic        in_ready, out_valid, wb_en, fwd_valid;
    logic [31:0] wb_data, fwd_data;
    logic [4:0]  wb_reg, fwd_reg;
    logic [1:0]  occupancy;
    logic [31:0] wb_count, mem_read_count, alu_result_count, stall_count;

    logic        s_in_ready, s_out_valid, s_wb_en, s_fwd_valid;
    logic [31:0] s_wb_data, s_fwd_data;
    logic [4:0]  s_wb_reg, s_fwd_reg;
    logic [1:0]  s_occupancy;
    logic [3:0]  s_wb_count, s_mem_read_count, s_alu_result_count, s_stall_count;

    mem_wb_skid_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .readdata_in(readdata_in), .alu_in(alu_in), .write_reg_in(write_reg_in),
        .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in), .out_valid(out_valid),
        .out_ready(out_ready), .wb_data(wb_data), .wb_reg(wb_reg), .wb_en(wb_en),
        .occupancy(occupancy), .wb_count(wb_count), .mem_read_count(mem_read_count),
        .alu_result_count(alu_result_count), .stall_count(stall_count),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation
    mem_wb_skid_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .readdata_in(readdata_in), .alu_in(alu_in), .write_reg_in(write_reg_in),
        .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in), .out_valid(s_out_valid),
        .out_ready(out_ready), .wb_data(s_wb_data), .wb_reg(s_wb_reg), .wb_en(s_wb_en),
        .occupancy(s_occupancy), .wb_count(s_wb_count), .mem_read_count(s_mem_read_count),
        .alu_result_count(s_alu_result_count), .stall_count(s_stall_count),
        .fwd_valid(s_fwd_valid), .fwd_reg(s_fwd_reg), .fwd_data(s_fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv, rdy, fl;
        logic [31:0] rd, alu;
        logic [4:0]  rg;
        logic        rw, m2r;
        int          exp_occ;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rg;
        logic        rw, m2r;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sbq[$];
    int unsigned m_wb, m_mem, m_alu, m_stall;
    int          tests, fails;

    function automatic vec_t mk(input logic iv, rdy, fl, input logic [31:0] rd, alu,
                                input logic [4:0] rg, input logic rw, m2r, input int occ);
        vec_t v;
        v.iv = iv; v.rdy = rdy; v.fl = fl; v.rd = rd; v.alu = alu;
        v.rg = rg; v.rw = rw; v.m2r = m2r; v.exp_occ = occ;
        return v;
    endfunction

    function automatic logic [3:0] sat4(input int unsigned v);
        return (v > 15) ? 4'hF : v[3:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = v.iv; out_ready = v.rdy; flush = v.fl;
        readdata_in = v.rd; alu_in = v.alu; write_reg_in = v.rg;
        regwrite_in = v.rw; memtoreg_in = v.m2r;
    endtask

    // One clock: pre-edge handshake checks and model update, post-edge state checks
    task automatic cycle(input int exp_occ);
        int   sz;
        bit   fire_m, acc_m, wben_m;
        exp_t e;
        @(negedge clk);
        sz     = sbq.size();
        fire_m = (sz > 0) && out_ready;
        acc_m  = in_valid && (sz < 2);
        wben_m = 1'b0;
        if (sz > 0) wben_m = fire_m && sbq[0].rw && (sbq[0].rg != 5'd0);
        if (!reset) begin
            chk("pre_out_valid", 64'(out_valid), 64'(sz > 0));
            chk("pre_in_ready", 64'(in_ready), 64'(sz < 2));
            chk("wb_en", 64'(wb_en), 64'(wben_m));
            if (fire_m) begin
                chk("sb_wb_data", 64'(wb_data), 64'(sbq[0].data));
                chk("sb_wb_reg", 64'(wb_reg), 64'(sbq[0].rg));
            end
        end
        if (reset) begin
            sbq.delete();
            m_wb = 0; m_mem = 0; m_alu = 0; m_stall = 0;
        end else begin
            if (wben_m) begin
                m_wb++;
                if (sbq[0].m2r) m_mem++; else m_alu++;
            end
            if (sz > 0 && !out_ready) m_stall++;
            if (fire_m) void'(sbq.pop_front());
            if (acc_m) begin
                e.data = memtoreg_in ? readdata_in : alu_in;
                e.rg = write_reg_in; e.rw = regwrite_in; e.m2r = memtoreg_in;
                sbq.push_back(e);
            end
            if (flush) sbq.delete();
        end
        @(posedge clk);
        #1;
        sz = sbq.size();
        if (exp_occ >= 0) chk("vec_occupancy", 64'(occupancy), 64'(exp_occ));
        chk("occupancy", 64'(occupancy), 64'(sz));
        chk("out_valid", 64'(out_valid), 64'(sz > 0));
        chk("in_ready", 64'(in_ready), 64'(sz < 2));
        if (sz > 0) chk("head_wb_data", 64'(wb_data), 64'(sbq[0].data));
        chk("wb_count", 64'(wb_count), 64'(m_wb));
        chk("mem_read_count", 64'(mem_read_count), 64'(m_mem));
        chk("alu_result_count", 64'(alu_result_count), 64'(m_alu));
        chk("stall_count", 64'(stall_count), 64'(m_stall));
        chk("sat_wb_count", 64'(s_wb_count), 64'(sat4(m_wb)));
        chk("sat_stall_count", 64'(s_stall_count), 64'(sat4(m_stall)));
`ifdef MEM_WB_BYPASS_EN
        if (sz > 0) begin
            e = sbq[sz-1];
            chk("fwd_valid", 64'(fwd_valid), 64'(e.rw && (e.rg != 5'd0)));
            chk("fwd_reg", 64'(fwd_reg), 64'(e.rg));
            chk("fwd_data", 64'(fwd_data), 64'(e.data));
        end else begin
            chk("fwd_valid", 64'(fwd_valid), 64'd0);
        end
`else
        chk("fwd_valid", 64'(fwd_valid), 64'd0);
        chk("fwd_reg", 64'(fwd_reg), 64'd0);
        chk("fwd_data", 64'(fwd_data), 64'd0);
`endif
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(vecs[i]);
            cycle(vecs[i].exp_occ);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, -1));
        cycle(-1);
        reset = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        m_wb = 0; m_mem = 0; m_alu = 0; m_stall = 0;
        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, -1));

        // Plan 1: streaming ALU beats (0-4)
        vecs.push_back(mk(1, 1, 0, 32'h0, 32'h11, 5'd1, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 32'h0, 32'h22, 5'd2, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 32'h0, 32'h33, 5'd3, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 32'h0, 32'h44, 5'd4, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0, 32'h0,  5'd0, 0, 0, 0));
        // Plan 2: stall with three offers, then drain (5-9)
        vecs.push_back(mk(1, 0, 0, 32'h0, 32'h55, 5'd5, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0, 32'h66, 5'd6, 1, 0, 2));
        vecs.push_back(mk(1, 0, 0, 32'h0, 32'h77, 5'd7, 1, 0, 2));
        vecs.push_back(mk(0, 1, 0, 32'h0, 32'h0,  5'd0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0, 32'h0,  5'd0, 0, 0, 0));
        // Plan 3: memory source, then same beat to r0 (10-12)
        vecs.push_back(mk(1, 1, 0, 32'hDEADBEEF, 32'h5, 5'd7, 1, 1, 1));
        vecs.push_back(mk(1, 1, 0, 32'hDEADBEEF, 32'h5, 5'd0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0));
        // Plan 4: flush at occupancy 2, flush with an accepted beat, flush with a fire (13-20)
        vecs.push_back(mk(1, 0, 0, 32'h0, 32'hA1, 5'd8, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0, 32'hB2, 5'd9, 1, 0, 2));
        vecs.push_back(mk(1, 0, 1, 32'h0, 32'hF3, 5'd10, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0, 32'hC4, 5'd11, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 32'h0, 32'hD5, 5'd12, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 32'h0,  5'd0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0, 32'hE6, 5'd13, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'h0, 32'h0,  5'd0, 0, 0, 0));
        // Plan 6: bypass source follows youngest entry (21-24)
        vecs.push_back(mk(1, 0, 0, 32'h0, 32'hA, 5'd3, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0, 32'hB, 5'd5, 1, 0, 2));
        vecs.push_back(mk(0, 1, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0));

        @(posedge clk); #1;
        do_reset();
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_wb_reg", 64'(wb_reg), 64'd0);

        run_vecs(0, 4);
        chk("p1_wb_count", 64'(wb_count), 64'd4);
        chk("p1_alu_count", 64'(alu_result_count), 64'd4);
        run_vecs(5, 9);
        chk("p2_stall_count", 64'(stall_count), 64'd2);
        run_vecs(10, 12);
        chk("p3_wb_count", 64'(wb_count), 64'd7);
        chk("p3_mem_count", 64'(mem_read_count), 64'd1);
        run_vecs(13, 20);
        chk("p4_wb_count", 64'(wb_count), 64'd8);

        // Plan 5: saturation of the narrow counters
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(mk(1, 1, 0, 32'h0, 32'(i + 1), 5'd1, 1, 0, -1));
            cycle(1);
        end
        drive(mk(0, 1, 0, 0, 0, 0, 0, 0, -1));
        cycle(0);
        chk("p5_wb_count16", 64'(wb_count), 64'd16);
        chk("p5_sat_wb", 64'(s_wb_count), 64'hF);
        chk("p5_sat_alu", 64'(s_alu_result_count), 64'hF);

        // Reset in the middle of a full stall
        drive(mk(1, 0, 0, 32'h0, 32'h91, 5'd2, 1, 0, -1));
        cycle(1);
        drive(mk(1, 0, 0, 32'h0, 32'h92, 5'd3, 1, 0, -1));
        cycle(2);
        reset = 1'b1;
        drive(mk(1, 0, 0, 32'h0, 32'h93, 5'd4, 1, 0, -1));
        cycle(0);
        reset = 1'b0;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_wb_data", 64'(wb_data), 64'd0);
        chk("mid_rst_wb_reg", 64'(wb_reg), 64'd0);
        chk("mid_rst_stall", 64'(stall_count), 64'd0);
        chk("mid_rst_sat_wb", 64'(s_wb_count), 64'd0);

        run_vecs(21, 24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid_reg.md
Name: mem_wb_skid_reg

Overview:
Parametrised, elastic MEM/WB pipeline stage. It replaces a fixed register with a 2-entry skid buffer and a valid/ready handshake on both sides, so writeback can stall without a combinational ready path back into MEM. It performs the writeback source select, suppresses writes to register 0, supports a synchronous flush, and keeps saturating performance counters. It sits between the data-memory stage and the register-file write port.

Parameters:
DATA_W, 32, width of memory read data, ALU result and writeback data
REG_AW, 5, register-file address width
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous flush; discards all buffered entries
in_valid  in  1  MEM-side beat valid
in_ready  out  1  stage can accept a beat; registered, equals !skid_valid
readdata_in  in  DATA_W  data-memory read data
alu_in  in  DATA_W  ALU result
write_reg_in  in  REG_AW  destination register
regwrite_in  in  1  instruction writes the register file
memtoreg_in  in  1  1 = writeback from memory, 0 = from ALU
out_valid  out  1  head entry valid
out_ready  in  1  WB side consumes the head this cycle
wb_data  out  DATA_W  head: memtoreg ? readdata : alu
wb_reg  out  REG_AW  head destination register
wb_en  out  1  out_valid & out_ready & regwrite & (wb_reg != 0)
occupancy  out  2  buffered entries, 0..2
wb_count  out  CNT_W  committed writebacks
mem_read_count  out  CNT_W  committed writebacks sourced from memory
alu_result_count  out  CNT_W  committed writebacks sourced from the ALU
stall_count  out  CNT_W  cycles with out_valid & !out_ready
fwd_valid  out  1  bypass entry valid (see Optional Feature)
fwd_reg  out  REG_AW  bypass destination register
fwd_data  out  DATA_W  bypass data

Behaviour:
- Storage: head slot H drives the out_* signals. Skid slot S holds the overflow beat. Each slot has a valid bit plus the payload {readdata, alu, write_reg, regwrite, memtoreg}.
- Handshake events:
  - accept = in_valid & in_ready
  - fire = out_valid & out_ready
  - out_valid = H.valid
- Per-cycle update, with reset and flush not active:
  - fire & S.valid: H <= S, S.valid <= 0. No accept can occur because in_ready = 0.
  - accept & (!H.valid | fire): H <= input beat, H.valid <= 1.
  - accept & H.valid & !fire: S <= input beat, S.valid <= 1.
  - fire & !accept & !S.valid: H.valid <= 0.
  - No event: hold all state.
- Latency is 1 cycle from accept to out_valid. Sustained throughput is 1 beat/cycle while out_ready = 1.
- Ordering: FIFO; beats leave in acceptance order and are never duplicated or dropped except by flush.
- in_ready depends only on registered state and has no combinational path from out_ready.
- occupancy = H.valid + S.valid.
- Flush: next cycle H.valid = S.valid = 0.
  - A beat accepted in the flush cycle is discarded.
  - Counters are not cleared; a head that fires in the flush cycle still counts.
- Reset: has priority over flush. All valid bits, payloads, counters, fwd_* and occupancy go to 0. in_ready = 1 in the cycle after reset. A reset mid-stall discards the buffered entries.
- Counters: saturate at all-ones and never wrap.
  - wb_count += wb_en.
  - mem_read_count += wb_en & memtoreg.
  - alu_result_count += wb_en & !memtoreg.
  - stall_count += out_valid & !out_ready.
  - A head with regwrite = 1 and wb_reg = 0 fires normally but asserts no wb_en and is not counted.
- wb_data and wb_reg are don't-care when out_valid = 0, but are driven from H (zeros after reset).

Optional Feature:
MEM_WB_BYPASS_EN
- Defined: fwd_* is driven from the youngest buffered entry, i.e. S if S.valid, else H.
  - fwd_valid = entry.valid & entry.regwrite & (entry.write_reg != 0).
  - fwd_data = the selected writeback source of that entry.
  - These outputs let the forwarding unit bypass stalled WB results.
- Undefined: fwd_valid, fwd_reg and fwd_data are tied to 0, and no bypass logic is generated. The ports exist in both builds.

Test Plan:
1. Reset, then a stream of 4 beats with out_ready = 1 (alu 0x11,0x22,0x33,0x44, regs 1..4, memtoreg = 0) -> wb_data follows 1 cycle after each accept; wb_count = 4, alu_result_count = 4, occupancy never exceeds 1.
2. out_ready = 0 while 3 beats are offered -> 2 accepted, in_ready = 0 from the cycle after the 2nd accept, occupancy = 2, stall_count counts each stalled cycle. Releasing out_ready drains in order with no loss.
3. memtoreg = 1, readdata 0xDEADBEEF, alu 0x5, reg 7 -> wb_data = 0xDEADBEEF, mem_read_count = 1. The same beat with reg 0 -> wb_en = 0 and counters unchanged.
4. occupancy = 2, then flush asserted together with an in_valid beat -> next cycle occupancy = 0, out_valid = 0, the beat is never output, counters unchanged.
5. Force wb_count to all-ones (CNT_W = 4 build, 15 commits) then commit one more -> wb_count stays 0xF. Reset mid-stall with occupancy = 2 -> all outputs 0 next cycle, in_ready = 1.
6. MEM_WB_BYPASS_EN build, with H = {reg 3, 0xA} and S = {reg 5, 0xB} -> fwd_reg = 5, fwd_data = 0xB. After H fires -> fwd_reg = 5 (now in H). Build without the macro -> fwd_* = 0 throughout.
